// File: rtl/lc3_decode_mt.sv
// Multi-context LC-3 decode stage: per-context register file, PSR and writeback
// scoreboard, with hazard stalls and a registered decode bundle to execute.

package lc3_decode_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RES  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_5,
    IMM_6,
    IMM_9,
    IMM_11
  } imm_sel_e;

  typedef struct packed {
    logic     use_sr1;
    logic     use_sr2;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic [2:0] dr;
    logic     wr_reg;
    logic     set_cc;
    logic     is_br;
    imm_sel_e imm_sel;
  } dec_t;

endpackage

module lc3_decode_mt
  import lc3_decode_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NCTX    = 1,
  parameter int CTX_W   = (NCTX > 1) ? $clog2(NCTX) : 1,
  parameter int CCQ_MAX = 7
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [15:0]         instr,
  input  logic [CTX_W-1:0]    instr_ctx,
  input  logic                wb_valid,
  input  logic [CTX_W-1:0]    wb_ctx,
  input  logic [2:0]          wb_dr,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                wb_set_cc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         out_ir,
  output logic [CTX_W-1:0]    out_ctx,
  output logic [DATA_W-1:0]   out_vsr1,
  output logic [DATA_W-1:0]   out_vsr2,
  output logic [DATA_W-1:0]   out_imm,
  output logic                out_br_taken,
  output logic                out_wr_reg,
  output logic                out_set_cc,
  output logic [3*NCTX-1:0]   psr_nzp
);

  // Storage is sized to every encodable context id; slots at or above NCTX are
  // never written, so they stay at their reset value and fold away.
  localparam int                NSLOT   = 1 << CTX_W;
  localparam int                CNT_W   = $clog2(CCQ_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CCQ_MAX);
  localparam logic [CTX_W:0]    NCTX_L  = (CTX_W + 1)'(NCTX);
  localparam logic [2:0]        PSR_RST = 3'b010;

  logic [DATA_W-1:0] reg_file [NSLOT][8];
  logic [7:0]        pending  [NSLOT];
  logic [2:0]        psr      [NSLOT];
  logic [CNT_W-1:0]  cc_cnt   [NSLOT];

  dec_t              dec;
  opcode_e           op;
  logic [DATA_W-1:0] imm;
  logic              ctx_ok;
  logic              wb_ok;
  logic              src_haz;
  logic              dr_haz;
  logic              br_haz;
  logic              cc_haz;
  logic              out_block;
  logic              issue;
  logic              br_taken;
  logic              cc_inc   [NSLOT];
  logic              cc_dec   [NSLOT];

  // ---------------------------------------------------------------- decode
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    op          = opcode_e'(instr[15:12]);
    dec         = '0;
    dec.sr1     = instr[8:6];
    dec.sr2     = instr[2:0];
    dec.dr      = instr[11:9];
    dec.imm_sel = IMM_NONE;
    unique case (op)
      OP_ADD, OP_AND: begin
        dec.use_sr1 = 1'b1;
        dec.use_sr2 = !instr[5];
        dec.wr_reg  = 1'b1;
        dec.set_cc  = 1'b1;
        dec.imm_sel = instr[5] ? IMM_5 : IMM_NONE;
      end
      OP_NOT: begin
        dec.use_sr1 = 1'b1;
        dec.wr_reg  = 1'b1;
        dec.set_cc  = 1'b1;
      end
      OP_LD, OP_LDI, OP_LEA: begin
        dec.wr_reg  = 1'b1;
        dec.set_cc  = 1'b1;
        dec.imm_sel = IMM_9;
      end
      OP_LDR: begin
        dec.use_sr1 = 1'b1;
        dec.wr_reg  = 1'b1;
        dec.set_cc  = 1'b1;
        dec.imm_sel = IMM_6;
      end
      OP_ST, OP_STI: begin
        dec.use_sr1 = 1'b1;
        dec.sr1     = instr[11:9];
        dec.imm_sel = IMM_9;
      end
      OP_STR: begin
        dec.use_sr1 = 1'b1;
        dec.use_sr2 = 1'b1;
        dec.sr2     = instr[11:9];
        dec.imm_sel = IMM_6;
      end
      OP_BR: begin
        dec.is_br   = 1'b1;
        dec.imm_sel = IMM_9;
      end
      OP_JMP: begin
        dec.use_sr1 = 1'b1;
      end
      OP_JSR: begin
        dec.wr_reg  = 1'b1;
        dec.dr      = 3'd7;
        dec.use_sr1 = !instr[11];
        dec.imm_sel = instr[11] ? IMM_11 : IMM_NONE;
      end
      default: begin
        // RTI, TRAP and the reserved opcode pass through with no effects.
      end
    endcase
  end

  always_comb begin
    imm = '0;
    unique case (dec.imm_sel)
      IMM_5:   imm = {{(DATA_W-5){instr[4]}},   instr[4:0]};
      IMM_6:   imm = {{(DATA_W-6){instr[5]}},   instr[5:0]};
      IMM_9:   imm = {{(DATA_W-9){instr[8]}},   instr[8:0]};
      IMM_11:  imm = {{(DATA_W-11){instr[10]}}, instr[10:0]};
      default: imm = '0;
    endcase
  end

  // ---------------------------------------------------------------- hazards
  always_comb begin
    ctx_ok    = {1'b0, instr_ctx} < NCTX_L;
    wb_ok     = wb_valid && ({1'b0, wb_ctx} < NCTX_L);
    src_haz   = (dec.use_sr1 && pending[instr_ctx][dec.sr1]) ||
                (dec.use_sr2 && pending[instr_ctx][dec.sr2]);
    dr_haz    = dec.wr_reg && pending[instr_ctx][dec.dr];
    br_haz    = dec.is_br && (cc_cnt[instr_ctx] != '0);
    cc_haz    = dec.set_cc && (cc_cnt[instr_ctx] == CNT_MAX);
    out_block = out_valid && !out_ready;
    instr_ready = !(src_haz || dr_haz || br_haz || cc_haz || out_block);
    issue     = instr_valid && instr_ready;
    br_taken  = dec.is_br && |(psr[instr_ctx] & instr[11:9]);
  end

  // A context may issue a CC-setter and retire one in the same cycle; the
  // two cancel. Retiring at zero leaves the counter at zero.
  always_comb begin
    for (int c = 0; c < NSLOT; c++) begin
      cc_inc[c] = issue && ctx_ok && dec.set_cc && (instr_ctx == CTX_W'(c));
      cc_dec[c] = wb_ok && wb_set_cc && (wb_ctx == CTX_W'(c)) && (cc_cnt[c] != '0);
    end
  end

  // ---------------------------------------------------------------- state
  // NOTE: the register file is reset with everything else because a reset must
  // leave every context architecturally zeroed, not merely unscoreboarded.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NSLOT; c++) begin
        for (int r = 0; r < 8; r++) reg_file[c][r] <= '0;
        pending[c] <= '0;
        psr[c]     <= PSR_RST;
        cc_cnt[c]  <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every read in
      // this block sees the pre-edge value regardless of statement order.
      if (wb_ok) begin
        reg_file[wb_ctx][wb_dr] <= wb_data;
        pending[wb_ctx][wb_dr]  <= 1'b0;
        if (wb_set_cc) begin
          psr[wb_ctx] <= {wb_data[DATA_W-1],
                          wb_data == '0,
                          !wb_data[DATA_W-1] && (wb_data != '0)};
        end
      end
      // DR-pending stalls guarantee this never targets the register being retired.
      if (issue && ctx_ok && dec.wr_reg) begin
        pending[instr_ctx][dec.dr] <= 1'b1;
      end
      for (int c = 0; c < NSLOT; c++) begin
        if (cc_inc[c] && !cc_dec[c])      cc_cnt[c] <= cc_cnt[c] + CNT_W'(1);
        else if (cc_dec[c] && !cc_inc[c]) cc_cnt[c] <= cc_cnt[c] - CNT_W'(1);
      end
    end
  end

  // Output bundle: loads on issue, holds while execute back-pressures.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_ir       <= '0;
      out_ctx      <= '0;
      out_vsr1     <= '0;
      out_vsr2     <= '0;
      out_imm      <= '0;
      out_br_taken <= 1'b0;
      out_wr_reg   <= 1'b0;
      out_set_cc   <= 1'b0;
    end else if (issue) begin
      out_valid    <= 1'b1;
      out_ir       <= instr;
      out_ctx      <= instr_ctx;
      out_vsr1     <= dec.use_sr1 ? reg_file[instr_ctx][dec.sr1] : '0;
      out_vsr2     <= dec.use_sr2 ? reg_file[instr_ctx][dec.sr2] : '0;
      out_imm      <= imm;
      out_br_taken <= br_taken;
      out_wr_reg   <= dec.wr_reg;
      out_set_cc   <= dec.set_cc;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  always_comb begin
    psr_nzp = '0;
    for (int c = 0; c < NCTX; c++) psr_nzp[3*c +: 3] = psr[c];
  end

endmodule

// File: tb/tb_lc3_decode_mt.sv
// Directed bench for lc3_decode_mt (two contexts): stimulus pushes hand-computed
// bundles into a queue, a monitor pops and compares each accepted bundle.

module tb_lc3_decode_mt;

  localparam int DATA_W = 16;
  localparam int NCTX   = 2;
  localparam int CTX_W  = 1;

  typedef struct packed {
    logic [15:0] ir;
    logic        ctx;
    logic [15:0] vsr1;
    logic [15:0] vsr2;
    logic [15:0] imm;
    logic        br;
    logic        wr;
    logic        cc;
  } bundle_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic [CTX_W-1:0]  instr_ctx;
  logic              wb_valid;
  logic [CTX_W-1:0]  wb_ctx;
  logic [2:0]        wb_dr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_set_cc;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_ir;
  logic [CTX_W-1:0]  out_ctx;
  logic [DATA_W-1:0] out_vsr1;
  logic [DATA_W-1:0] out_vsr2;
  logic [DATA_W-1:0] out_imm;
  logic              out_br_taken;
  logic              out_wr_reg;
  logic              out_set_cc;
  logic [3*NCTX-1:0] psr_nzp;

  int      vectors     = 0;
  int      miscompares = 0;
  bundle_t exp_q[$];

  lc3_decode_mt #(.DATA_W(DATA_W), .NCTX(NCTX), .CTX_W(CTX_W), .CCQ_MAX(7)) dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_ctx(instr_ctx),
    .wb_valid(wb_valid), .wb_ctx(wb_ctx), .wb_dr(wb_dr),
    .wb_data(wb_data), .wb_set_cc(wb_set_cc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ir(out_ir), .out_ctx(out_ctx),
    .out_vsr1(out_vsr1), .out_vsr2(out_vsr2), .out_imm(out_imm),
    .out_br_taken(out_br_taken), .out_wr_reg(out_wr_reg), .out_set_cc(out_set_cc),
    .psr_nzp(psr_nzp)
  );

  always #5 clock = ~clock;

  function automatic bundle_t mk(input logic [15:0] ir, input logic ctx,
                                 input logic [15:0] v1, input logic [15:0] v2,
                                 input logic [15:0] im, input logic br,
                                 input logic wr, input logic cc);
    bundle_t b;
    b = '{ir: ir, ctx: ctx, vsr1: v1, vsr2: v2, imm: im, br: br, wr: wr, cc: cc};
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer an instruction; it must become ready within max_wait extra cycles.
  task automatic issue(input logic [15:0] ins, input logic ctx, input bundle_t e,
                       input int max_wait);
    int waited;
    waited      = 0;
    instr       = ins;
    instr_ctx   = ctx;
    instr_valid = 1'b1;
    @(negedge clock);
    while (!instr_ready && waited < max_wait) begin
      @(negedge clock);
      waited++;
    end
    vectors++;
    if (!instr_ready) begin
      miscompares++;
      $display("FAIL issue %h: instr_ready=0 after %0d cycles, expected 1", ins, waited);
    end else begin
      exp_q.push_back(e);
    end
    tick();
    instr_valid = 1'b0;
  endtask

  // Offer an instruction and require it to stay stalled for n cycles.
  task automatic expect_stall(input logic [15:0] ins, input logic ctx, input int n);
    instr       = ins;
    instr_ctx   = ctx;
    instr_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check($sformatf("stall %h", ins), instr_ready, 0);
    end
    tick();
  endtask

  task automatic wb(input logic ctx, input logic [2:0] dr, input logic [15:0] data,
                    input logic cc, input logic chk_stall);
    wb_ctx    = ctx;
    wb_dr     = dr;
    wb_data   = data;
    wb_set_cc = cc;
    wb_valid  = 1'b1;
    @(negedge clock);
    if (chk_stall) check("stall in wb cycle", instr_ready, 0);
    tick();
    wb_valid  = 1'b0;
  endtask

  // Monitor: a bundle is consumed on the edge after a negedge with valid & ready.
  always @(negedge clock) begin
    bundle_t got;
    bundle_t e;
    if (!reset && out_valid && out_ready) begin
      got = mk(out_ir, out_ctx, out_vsr1, out_vsr2, out_imm,
               out_br_taken, out_wr_reg, out_set_cc);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL bundle unexpected: got %h, expected none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          miscompares++;
          $display("FAIL bundle ir=%h: got %h, expected %h", e.ir, got, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ir;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    instr_ctx   = '0;
    wb_valid    = 1'b0;
    wb_ctx      = '0;
    wb_dr       = '0;
    wb_data     = '0;
    wb_set_cc   = 1'b0;
    out_ready   = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clock);
    check("reset psr_nzp", psr_nzp, 6'b010010);
    check("reset out_valid", out_valid, 0);
    instr = 16'h12BD;
    #1 check("reset instr_ready", instr_ready, 1);
    tick();

    // ADD with imm, then RAW on R1 until writeback
    issue(16'h12BD, 0, mk(16'h12BD, 0, 16'h0000, 16'h0000, 16'hFFFD, 0, 1, 1), 0);
    expect_stall(16'h1641, 0, 2);
    wb(0, 3'd1, 16'h0005, 1, 1);
    issue(16'h1641, 0, mk(16'h1641, 0, 16'h0005, 16'h0005, 16'h0000, 0, 1, 1), 0);
    check("psr ctx0 after +5", psr_nzp[2:0], 3'b001);
    wb(0, 3'd3, 16'h000A, 1, 0);

    // BR waits for outstanding CC producer
    issue(16'h2805, 0, mk(16'h2805, 0, 16'h0000, 16'h0000, 16'h0005, 0, 1, 1), 0);
    expect_stall(16'h0802, 0, 2);
    wb(0, 3'd4, 16'h8000, 1, 1);
    issue(16'h0802, 0, mk(16'h0802, 0, 16'h0000, 16'h0000, 16'h0002, 1, 0, 0), 0);
    issue(16'h05FF, 0, mk(16'h05FF, 0, 16'h0000, 16'h0000, 16'hFFFF, 0, 0, 0), 0);
    check("psr ctx0 negative", psr_nzp[2:0], 3'b100);

    // Context isolation
    issue(16'h1261, 0, mk(16'h1261, 0, 16'h0005, 16'h0000, 16'h0001, 0, 1, 1), 0);
    issue(16'h1460, 1, mk(16'h1460, 1, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1), 0);
    wb(0, 3'd1, 16'hFFFF, 1, 0);
    @(negedge clock);
    check("psr ctx1 unaffected", psr_nzp, 6'b010100);
    tick();
    wb(1, 3'd2, 16'h0007, 1, 0);
    @(negedge clock);
    check("psr ctx1 positive", psr_nzp, 6'b001100);
    tick();

    // JSR/JSRR R7 WAW, STR with pending SR2, no CC change
    issue(16'h4FFE, 0, mk(16'h4FFE, 0, 16'h0000, 16'h0000, 16'hFFFE, 0, 1, 0), 0);
    expect_stall(16'h40C0, 0, 2);
    wb(0, 3'd7, 16'h1234, 0, 1);
    issue(16'h40C0, 0, mk(16'h40C0, 0, 16'h000A, 16'h0000, 16'h0000, 0, 1, 0), 0);
    expect_stall(16'h7EFF, 0, 2);
    wb(0, 3'd7, 16'h4321, 0, 1);
    issue(16'h7EFF, 0, mk(16'h7EFF, 0, 16'h000A, 16'h4321, 16'hFFFF, 0, 0, 0), 0);
    check("psr ctx0 held by non-cc wb", psr_nzp[2:0], 3'b100);
    issue(16'hD123, 0, mk(16'hD123, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0), 0);
    tick();

    // Back-pressure: bundle holds, next instruction stalls, then issues on release
    out_ready = 1'b0;
    issue(16'h9A7F, 0, mk(16'h9A7F, 0, 16'hFFFF, 16'h0000, 16'h0000, 0, 1, 1), 0);
    instr       = 16'hEC03;
    instr_ctx   = 0;
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("backpressure instr_ready", instr_ready, 0);
      check("backpressure out_ir", out_ir, 16'h9A7F);
      check("backpressure out_valid", out_valid, 1);
    end
    tick();
    out_ready = 1'b1;
    issue(16'hEC03, 0, mk(16'hEC03, 0, 16'h0000, 16'h0000, 16'h0003, 0, 1, 1), 0);
    wb(0, 3'd5, 16'h0000, 1, 0);
    wb(0, 3'd6, 16'h0003, 1, 0);

    // CC counter saturation on ctx1
    for (int k = 0; k < 7; k++) begin
      ir = 16'hE000 | 16'(k << 9) | 16'(k);
      issue(ir, 1, mk(ir, 1, 16'h0000, 16'h0000, 16'(k), 0, 1, 1), 0);
    end
    expect_stall(16'hEE07, 1, 2);
    wb(1, 3'd0, 16'h0001, 1, 1);
    issue(16'hEE07, 1, mk(16'hEE07, 1, 16'h0000, 16'h0000, 16'h0007, 0, 1, 1), 0);
    tick();

    // Reset in the middle of a held bundle and a stall
    out_ready   = 1'b0;
    instr       = 16'hD000;
    instr_ctx   = 1;
    instr_valid = 1'b1;
    tick();
    check("held bundle before reset", out_valid, 1);
    instr = 16'h1261;
    @(negedge clock);
    check("stall before reset", instr_ready, 0);
    #2 reset = 1'b1;
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset out_ir", out_ir, 16'h0000);
    check("async reset psr_nzp", psr_nzp, 6'b010010);
    @(negedge clock);
    reset       = 1'b0;
    instr_valid = 1'b0;
    out_ready   = 1'b1;
    tick();
    issue(16'hE201, 1, mk(16'hE201, 1, 16'h0000, 16'h0000, 16'h0001, 0, 1, 1), 0);
    issue(16'h1261, 0, mk(16'h1261, 0, 16'h0000, 16'h0000, 16'h0001, 0, 1, 1), 0);

    repeat (3) tick();
    check("expected queue drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lc3_decode_mt.md
# lc3_decode_mt

Parametrised, multi-context successor to the LC-3 decode stage. Accepts fetched instructions over a valid/ready handshake and keeps one register file and PSR per hardware context. It tracks outstanding writebacks with a per-register scoreboard, stalls on RAW/WAW and condition-code hazards, and emits a registered decode bundle to execute. It sits between fetch/memory and execute; writeback returns through a dedicated port.

## Interface
Parameters:
- DATA_W, 16: register/data width; must be ≥ 16. Instructions are always 16 bits.
- NCTX, 1: number of hardware contexts; each has 8 registers and its own PSR.
- CTX_W, max(1,$clog2(NCTX)): context-id width.
- CCQ_MAX, 7: maximum outstanding CC-setting instructions per context.

Ports:
- clock  in  1  global system clock
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  instruction accepted this cycle (combinational)
- instr  in  16  instruction word
- instr_ctx  in  CTX_W  context of instr
- wb_valid  in  1  writeback strobe
- wb_ctx  in  CTX_W  writeback context
- wb_dr  in  3  writeback register
- wb_data  in  DATA_W  writeback value
- wb_set_cc  in  1  writeback updates PSR
- out_valid  out  1  decode bundle valid
- out_ready  in  1  execute accepts bundle
- out_ir  out  16  issued instruction
- out_ctx  out  CTX_W  issued context
- out_vsr1  out  DATA_W  SR1 value
- out_vsr2  out  DATA_W  SR2 value
- out_imm  out  DATA_W  sign-extended immediate/offset
- out_br_taken  out  1  branch condition met
- out_wr_reg  out  1  instruction writes a register
- out_set_cc  out  1  instruction sets CC
- psr_nzp  out  3*NCTX  {N,Z,P} per context; context c at bits [3c+2:3c]

## Operation
- Field decode uses the LC-3 opcodes from the package.
  - SR1 = IR[8:6] for ADD/AND/NOT/JMP/JSRR/LDR/STR.
  - SR1 = IR[11:9] for ST/STI.
  - SR2 = IR[2:0] for ADD/AND when IR[5]=0.
  - SR2 = IR[11:9] for STR.
  - DR = IR[11:9]; JSR/JSRR use DR=7.
- Register writers:
  - ADD, AND, NOT, LD, LDR, LDI, LEA write a register and set CC.
  - JSR/JSRR write R7 and do not set CC.
- out_imm (sign-extended to DATA_W):
  - imm5 for ADD/AND with IR[5]=1.
  - off6 for LDR/STR.
  - off9 for BR/LD/LDI/ST/STI/LEA.
  - off11 for JSR with IR[11]=1.
  - 0 otherwise.
- Scoreboard: one pending bit per (ctx, reg) and one CC counter per ctx (0..CCQ_MAX).
- An instruction is stalled (instr_ready=0) when any of the following holds:
  - a used source register is pending;
  - its DR is pending;
  - it is BR and the context's CC counter ≠ 0;
  - it sets CC and the counter = CCQ_MAX;
  - out_valid=1 and out_ready=0.
- Issue happens when instr_valid & instr_ready. On issue:
  - the output register loads the bundle;
  - pending[ctx][DR] is set if the instruction writes a register;
  - the CC counter increments if the instruction sets CC.
- Writeback (wb_valid):
  - writes reg_file[wb_ctx][wb_dr];
  - clears pending[wb_ctx][wb_dr];
  - if wb_set_cc: PSR ← {N=msb, Z=(data==0), P=!msb&&data≠0}, and the counter decrements. At counter 0 the PSR still updates and the counter holds at 0.
- Simultaneous issue set and writeback clear on different registers both take effect. The same register cannot collide because DR-pending stalls.
- Writes to a context's R7 by JSR are ordinary pending writes.
- out_br_taken = (N&IR[11])|(Z&IR[10])|(P&IR[9]) from the PSR at issue; 0 for non-BR.
- Undefined or reserved opcodes issue with all flags 0, out_imm 0, and no scoreboard effect.

## Timing
- Reset asynchronous:
  - all registers and PSRs → 0, then PSR ← 3'b010 (Z);
  - scoreboard and counters → 0;
  - out_valid and all out_* → 0.
- A reset mid-stall or mid-bundle discards everything.
- Latency: issue in cycle t → out_valid=1 in cycle t+1.
- The bundle holds stable while out_valid & !out_ready.
- With out_ready held high and no hazards, throughput is 1 instruction per cycle.
- Register reads are taken from the array at issue; there is no writeback bypass.
  - A source whose writeback arrives in cycle t stalls in t and issues in t+1 with the new value.
- PSR and scoreboard update on the clock edge ending the writeback cycle.
- instr_ready is combinational from instr, instr_ctx, scoreboard, out_valid and out_ready; fetch must not make instr_valid depend on instr_ready.

## Test plan
- Reset, then read psr_nzp → 3'b010 for every context; out_valid=0; instr_ready=1 for a hazard-free instr.
- ctx0 ADD R1,R2,#-3 (0x12BD) issue → next cycle out_imm=0xFFFD, out_wr_reg=1, out_set_cc=1; a following ADD R3,R1,R1 is stalled until wb_valid(ctx0,R1,0x0005,cc=1), then issues with out_vsr1=out_vsr2=0x0005 and psr_nzp[2:0]=3'b001.
- BRn after LD with writeback pending → instr_ready=0; after wb 0x8000 with cc, BRn issues with out_br_taken=1 and BRz gives 0.
- NCTX=2: ctx0 R1 pending, ctx1 ADD reading R1 issues immediately; ctx1 psr unaffected by ctx0 wb.
- Hold out_ready=0 with a bundle valid → bundle stable and instr_ready=0 for 5 cycles; release → next instruction issues the same cycle.
- Issue CCQ_MAX CC-setters without writeback → the next CC-setter stalls; one wb_set_cc → it issues the following cycle. Assert reset mid-sequence → all counters 0, out_valid=0 immediately.
